adder_pipe_hs: RTL and testbench

- Parametrised successor of the team's registered 8-bit adder.
- Adds or subtracts two WIDTH-bit operands and returns an exact WIDTH+1-bit result, with optional saturation to WIDTH bits.
- Result passes through a configurable pipeline with valid/ready handshakes on both sides.
- Sits between a streaming operand source and a result consumer that may apply backpressure.

---
 rtl/adder_pipe_hs.sv | 120 ++++++++++++
 tb/tb_adder_pipe_hs.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_hs.sv
// adder_pipe_hs: WIDTH-bit add/subtract with exact WIDTH+1-bit result and optional
// saturation, followed by a STAGES-deep valid/ready pipeline and a delivered-beat counter.
module adder_pipe_hs #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             op_sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum_o,
    output logic             ovf_o,
    output logic [15:0]      beat_cnt_o
);

    localparam int NS = int'(STAGES);

    // Clamp values, already extended to WIDTH+1 bits.
    localparam logic [WIDTH:0] UMAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] SMAX = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0] SMIN = {2'b11, {(WIDTH-1){1'b0}}};

    logic             w_advance;
    logic             w_accept;
    logic             w_xfer;
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_raw;
    logic [WIDTH:0]   w_res;
    logic             w_ovf;

    logic             r_live;
    logic [NS-1:0]    r_vld;
    logic [NS-1:0]    r_ovf;
    logic [WIDTH:0]   r_sum [NS];
    logic [15:0]      r_cnt;

    assign out_valid  = r_vld[NS-1];
    assign sum_o      = r_sum[NS-1];
    assign ovf_o      = r_ovf[NS-1];
    assign beat_cnt_o = r_cnt;

    // The whole pipe moves as one unit whenever the output slot is free or draining.
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = r_live && w_advance;
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = out_valid && out_ready;

    // Stage-1 arithmetic: extend, add/sub exactly, flag range overflow, optionally clamp.
    always_comb begin
        if (SIGNED != 0) begin
            w_a_ext = {a_in[WIDTH-1], a_in};
            w_b_ext = {b_in[WIDTH-1], b_in};
        end else begin
            w_a_ext = {1'b0, a_in};
            w_b_ext = {1'b0, b_in};
        end
        w_raw = op_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
        if (SIGNED != 0) begin
            w_ovf = w_raw[WIDTH] != w_raw[WIDTH-1];
        end else begin
            w_ovf = w_raw[WIDTH];
        end
        w_res = w_raw;
        if (sat_en && w_ovf) begin
            if (SIGNED != 0) begin
                // The exact result's top bit is its true sign.
                w_res = w_raw[WIDTH] ? SMIN : SMAX;
            end else begin
                w_res = op_sub ? '0 : UMAX;
            end
        end
    end

    // in_ready stays low until the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Pipeline shift register; bubbles are carried, not squeezed out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_ovf <= '0;
            for (int i = 0; i < NS; i++) begin
                r_sum[i] <= '0;
            end
        end else if (w_advance) begin
            r_vld[0] <= w_accept;
            r_ovf[0] <= w_ovf;
            r_sum[0] <= w_res;
            for (int i = 1; i < NS; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_ovf[i] <= r_ovf[i-1];
                r_sum[i] <= r_sum[i-1];
            end
        end
    end

    // Count delivered results, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_adder_pipe_hs.sv
// Scoreboard bench: an unsigned default instance (STAGES=2) and a signed STAGES=3 instance.
module tb_adder_pipe_hs;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       sat;
        logic [8:0] es;
        logic       eo;
    } vec_t;

    typedef struct packed {
        logic [8:0] sum;
        logic       ovf;
    } exp_t;

    // Hand-computed unsigned vectors (WIDTH=8).
    localparam vec_t UV [8] = '{
        '{8'd200, 8'd100, 1'b0, 1'b0, 9'h12C, 1'b1},
        '{8'd200, 8'd100, 1'b0, 1'b1, 9'h0FF, 1'b1},
        '{8'd5,   8'd9,   1'b1, 1'b1, 9'h000, 1'b1},
        '{8'd5,   8'd9,   1'b1, 1'b0, 9'h1FC, 1'b1},
        '{8'd10,  8'd20,  1'b0, 1'b1, 9'h01E, 1'b0},
        '{8'd255, 8'd255, 1'b0, 1'b0, 9'h1FE, 1'b1},
        '{8'd9,   8'd5,   1'b1, 1'b1, 9'h004, 1'b0},
        '{8'd255, 8'd1,   1'b0, 1'b1, 9'h0FF, 1'b1}
    };

    // Hand-computed signed vectors (WIDTH=8, two's complement).
    localparam vec_t SV [10] = '{
        '{8'h64, 8'h64, 1'b0, 1'b1, 9'h07F, 1'b1},
        '{8'h9C, 8'h64, 1'b1, 1'b1, 9'h180, 1'b1},
        '{8'hFD, 8'h02, 1'b0, 1'b1, 9'h1FF, 1'b0},
        '{8'h64, 8'h64, 1'b0, 1'b0, 9'h0C8, 1'b1},
        '{8'h9C, 8'h64, 1'b1, 1'b0, 9'h138, 1'b1},
        '{8'h32, 8'h14, 1'b1, 1'b1, 9'h01E, 1'b0},
        '{8'h80, 8'h80, 1'b0, 1'b1, 9'h180, 1'b1},
        '{8'h7F, 8'hFF, 1'b1, 1'b1, 9'h07F, 1'b1},
        '{8'hFF, 8'h7F, 1'b1, 1'b0, 9'h180, 1'b0},
        '{8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 1'b0}
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       u_in_valid, u_in_ready, u_op_sub, u_sat_en, u_out_valid, u_out_ready, u_ovf;
    logic [7:0] u_a, u_b;
    logic [8:0] u_sum;
    logic [15:0] u_cnt;
    logic       s_in_valid, s_in_ready, s_op_sub, s_sat_en, s_out_valid, s_out_ready, s_ovf;
    logic [7:0] s_a, s_b;
    logic [8:0] s_sum;
    logic [15:0] s_cnt;

    int          checks = 0;
    int          errors = 0;
    exp_t        u_q [$];
    exp_t        s_q [$];
    logic [15:0] u_exp_cnt = '0;
    logic [15:0] s_exp_cnt = '0;
    bit          live = 1'b0;
    bit          sdone = 1'b0;

    adder_pipe_hs u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (u_in_valid),
        .in_ready   (u_in_ready),
        .a_in       (u_a),
        .b_in       (u_b),
        .op_sub     (u_op_sub),
        .sat_en     (u_sat_en),
        .out_valid  (u_out_valid),
        .out_ready  (u_out_ready),
        .sum_o      (u_sum),
        .ovf_o      (u_ovf),
        .beat_cnt_o (u_cnt)
    );

    adder_pipe_hs #(
        .WIDTH  (8),
        .STAGES (3),
        .SIGNED (1)
    ) s_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .a_in       (s_a),
        .b_in       (s_b),
        .op_sub     (s_op_sub),
        .sat_en     (s_sat_en),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .sum_o      (s_sum),
        .ovf_o      (s_ovf),
        .beat_cnt_o (s_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Unsigned instance monitor: result order/value, hold stability, in_ready, beat count.
    logic [8:0] u_hsum;
    logic       u_hovf;
    bit         u_hold = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            u_hold = 1'b0;
        end else begin
            if (u_hold) begin
                check("u_hold_valid", u_out_valid, 1);
                check("u_hold_sum", u_sum, u_hsum);
                check("u_hold_ovf", u_ovf, u_hovf);
            end
            if (live) check("u_in_ready", u_in_ready, !(u_out_valid && !u_out_ready));
            check("u_beat_cnt", u_cnt, u_exp_cnt);
            if (u_out_valid && u_out_ready) begin
                if (u_q.size() == 0) begin
                    check("u_unexpected_beat", 1, 0);
                end else begin
                    e = u_q.pop_front();
                    check("u_sum", u_sum, e.sum);
                    check("u_ovf", u_ovf, e.ovf);
                end
                u_exp_cnt = u_exp_cnt + 16'd1;
            end
            u_hold = u_out_valid && !u_out_ready;
            u_hsum = u_sum;
            u_hovf = u_ovf;
        end
    end

    // Signed instance monitor, same checks.
    logic [8:0] s_hsum;
    logic       s_hovf;
    bit         s_hold = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            s_hold = 1'b0;
        end else begin
            if (s_hold) begin
                check("s_hold_valid", s_out_valid, 1);
                check("s_hold_sum", s_sum, s_hsum);
                check("s_hold_ovf", s_ovf, s_hovf);
            end
            if (live) check("s_in_ready", s_in_ready, !(s_out_valid && !s_out_ready));
            check("s_beat_cnt", s_cnt, s_exp_cnt);
            if (s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) begin
                    check("s_unexpected_beat", 1, 0);
                end else begin
                    e = s_q.pop_front();
                    check("s_sum", s_sum, e.sum);
                    check("s_ovf", s_ovf, e.ovf);
                end
                s_exp_cnt = s_exp_cnt + 16'd1;
            end
            s_hold = s_out_valid && !s_out_ready;
            s_hsum = s_sum;
            s_hovf = s_ovf;
        end
    end

    // Present one beat (sel=1: signed instance) and push its expectation on acceptance.
    task automatic send(input bit sel, input vec_t v);
        int  n = 0;
        bit  rdy;
        if (sel) begin
            s_in_valid = 1'b1; s_a = v.a; s_b = v.b; s_op_sub = v.sub; s_sat_en = v.sat;
        end else begin
            u_in_valid = 1'b1; u_a = v.a; u_b = v.b; u_op_sub = v.sub; u_sat_en = v.sat;
        end
        @(negedge clk);
        rdy = sel ? s_in_ready : u_in_ready;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
            rdy = sel ? s_in_ready : u_in_ready;
        end
        if (!rdy) check("accept_timeout", 0, 1);
        else if (sel) s_q.push_back(exp_t'{v.es, v.eo});
        else u_q.push_back(exp_t'{v.es, v.eo});
        @(posedge clk);
        #1;
    endtask

    // Called right after a send returns with the input idle: cycles until out_valid.
    task automatic lat_check(input bit sel, input int exp_lat, input string name);
        int n = 0;
        bit v;
        do begin
            @(negedge clk);
            n++;
            v = sel ? s_out_valid : u_out_valid;
        end while (!v && n < 20);
        check(name, n, exp_lat);
        @(negedge clk);
        check({name, "_single_cycle"}, sel ? s_out_valid : u_out_valid, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((u_q.size() != 0 || s_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (u_q.size() != 0 || s_q.size() != 0), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_u_out_valid"}, u_out_valid, 0);
        check({tag, "_u_sum"}, u_sum, 0);
        check({tag, "_u_ovf"}, u_ovf, 0);
        check({tag, "_u_cnt"}, u_cnt, 0);
        check({tag, "_u_in_ready"}, u_in_ready, 0);
        check({tag, "_s_out_valid"}, s_out_valid, 0);
        check({tag, "_s_sum"}, s_sum, 0);
        check({tag, "_s_cnt"}, s_cnt, 0);
        check({tag, "_s_in_ready"}, s_in_ready, 0);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("u_in_ready_after_rst", u_in_ready, 1);
        check("s_in_ready_after_rst", s_in_ready, 1);
        live = 1'b1;
    endtask

    initial begin
        vec_t w;
        rst = 1'b1;
        u_in_valid = 1'b0; u_a = '0; u_b = '0; u_op_sub = 1'b0; u_sat_en = 1'b0;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_op_sub = 1'b0; s_sat_en = 1'b0;
        u_out_ready = 1'b1;
        s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        release_rst();

        // Unsigned: latency 2 and a one-cycle result, then the remaining vectors streamed.
        send(1'b0, UV[0]);
        u_in_valid = 1'b0;
        lat_check(1'b0, 2, "u_latency");
        @(posedge clk);
        #1;
        check("u_cnt_first", u_cnt, 1);
        for (int i = 1; i < 8; i++) send(1'b0, UV[i]);
        u_in_valid = 1'b0;
        wait_drain();

        // Signed, STAGES=3: back-to-back beats under out_ready pattern 1,0,0,1,0,0,...
        fork
            begin
                for (int i = 0; i < 10; i++) send(1'b1, SV[i]);
                s_in_valid = 1'b0;
                sdone = 1'b1;
            end
            begin
                for (int k = 0; k < 300 && !(sdone && s_q.size() == 0); k++) begin
                    s_out_ready = (k % 3 == 0);
                    @(posedge clk);
                    #1;
                end
                s_out_ready = 1'b1;
            end
        join
        wait_drain();
        check("s_cnt_after_backpressure", s_cnt, 10);

        // Reset with three beats in flight: nothing stale may come out afterwards.
        for (int i = 0; i < 3; i++) send(1'b1, SV[i]);
        s_in_valid = 1'b0;
        live = 1'b0;
        u_q.delete();
        s_q.delete();
        u_exp_cnt = '0;
        s_exp_cnt = '0;
        rst = 1'b1;
        #1;
        reset_checks("mid");
        repeat (2) @(posedge clk);
        #1;
        release_rst();
        send(1'b1, SV[5]);
        s_in_valid = 1'b0;
        lat_check(1'b1, 3, "s_latency_after_rst");
        wait_drain();

        // Counter wrap: 65536 beats bring it back to 0, one more gives 1.
        for (int i = 0; i < 65536; i++) begin
            w = '{i[7:0], 8'd0, 1'b0, 1'b0, {1'b0, i[7:0]}, 1'b0};
            send(1'b0, w);
        end
        u_in_valid = 1'b0;
        wait_drain();
        check("u_cnt_wrapped", u_cnt, 0);
        send(1'b0, UV[4]);
        u_in_valid = 1'b0;
        wait_drain();
        check("u_cnt_after_wrap", u_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
